sawtooth_sweep_sequencer: RTL and testbench

//  Sequences freq_select of the sawtooth generator through a frequency sweep.

---
 rtl/sawtooth_sweep_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_sawtooth_sweep_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sawtooth_sweep_sequencer.sv
// sawtooth_sweep_sequencer
// Steps the sawtooth generator's freq_select through a sweep between two
// programmable levels. Supported sweeps are up, down, ping-pong and hold.
// Each level is held for a programmable dwell. The sweep repeats for a set
// number of loops, or forever when loops is 0. A generator-reset pulse is
// issued when the sweep starts.
module sawtooth_sweep_sequencer #(
    parameter int         DWELL_W     = 16,
    parameter int         LOOP_W      = 8,
    parameter logic [2:0] DEFAULT_SEL = 3'b000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [2:0]         lo_sel,
    input  logic [2:0]         hi_sel,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [LOOP_W-1:0]  loops,
    output logic [2:0]         freq_select,
    output logic               step_strobe,
    output logic               wave_rst,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    state_t             state;

    // Copies of the configuration, captured when the sweep starts
    logic [1:0]         mode_q;
    logic [2:0]         lo_q;
    logic [2:0]         hi_q;
    logic [DWELL_W-1:0] dwell_last_q;
    logic [LOOP_W-1:0]  loops_q;

    // Sweep progress
    logic [DWELL_W-1:0] dwell_cnt;
    logic [LOOP_W-1:0]  loop_cnt;
    logic               desc_q;

    // Values derived combinationally from the inputs and from the latched copies
    logic [2:0]         launch_level;
    logic [DWELL_W-1:0] launch_dwell_last;
    logic [2:0]         run_start_level;
    logic [2:0]         next_level;
    logic               next_desc;
    logic               expiry;
    logic               loop_end;
    logic               final_loop;

    // Start level and last dwell count for a sweep about to launch; a dwell of 0 behaves as 1
    always_comb begin
        launch_level      = (mode == MODE_DOWN) ? hi_sel : lo_sel;
        launch_dwell_last = (dwell == '0) ? '0 : (dwell - 1'b1);
    end

    // Next level of the running sweep, and whether the expiry closes a loop
    always_comb begin
        run_start_level = (mode_q == MODE_DOWN) ? hi_q : lo_q;
        next_level      = freq_select;
        next_desc       = desc_q;
        case (mode_q)
            MODE_UP: begin
                if (freq_select == hi_q) begin
                    next_level = lo_q;
                end else begin
                    next_level = freq_select + 3'd1;
                end
            end
            MODE_DOWN: begin
                if (freq_select == lo_q) begin
                    next_level = hi_q;
                end else begin
                    next_level = freq_select - 3'd1;
                end
            end
            MODE_PING: begin
                if (!desc_q) begin
                    if (freq_select == hi_q) begin
                        if (hi_q == lo_q) begin
                            next_level = lo_q;
                        end else begin
                            next_level = freq_select - 3'd1;
                            next_desc  = 1'b1;
                        end
                    end else begin
                        next_level = freq_select + 3'd1;
                    end
                end else begin
                    if (freq_select == lo_q) begin
                        next_level = lo_q;
                    end else begin
                        next_level = freq_select - 3'd1;
                    end
                end
            end
            default: begin
                next_level = freq_select;
            end
        endcase
        expiry     = (dwell_cnt == dwell_last_q);
        loop_end   = (next_level == run_start_level);
        final_loop = (loops_q != '0) && (loop_cnt == (loops_q - 1'b1));
    end

    // Sweep controller: state, latched configuration, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            mode_q       <= MODE_UP;
            lo_q         <= 3'd0;
            hi_q         <= 3'd0;
            dwell_last_q <= '0;
            loops_q      <= '0;
            dwell_cnt    <= '0;
            loop_cnt     <= '0;
            desc_q       <= 1'b0;
            freq_select  <= DEFAULT_SEL;
            step_strobe  <= 1'b0;
            wave_rst     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            wave_rst    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            case (state)
                IDLE: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (start) begin
                        if (lo_sel > hi_sel) begin
                            err <= 1'b1;
                        end else begin
                            mode_q       <= mode;
                            lo_q         <= lo_sel;
                            hi_q         <= hi_sel;
                            dwell_last_q <= launch_dwell_last;
                            loops_q      <= loops;
                            dwell_cnt    <= '0;
                            loop_cnt     <= '0;
                            desc_q       <= 1'b0;
                            freq_select  <= launch_level;
                            step_strobe  <= 1'b1;
                            wave_rst     <= 1'b1;
                            busy         <= 1'b1;
                            state        <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (expiry) begin
                        dwell_cnt <= '0;
                        if (loop_end) begin
                            if (final_loop) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                freq_select <= run_start_level;
                                step_strobe <= 1'b1;
                                desc_q      <= 1'b0;
                                if (loops_q != '0) begin
                                    loop_cnt <= loop_cnt + 1'b1;
                                end
                            end
                        end else begin
                            freq_select <= next_level;
                            desc_q      <= next_desc;
                            step_strobe <= 1'b1;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sawtooth_sweep_sequencer.sv
// tb_sawtooth_sweep_sequencer
// Directed bench for the sweep sequencer. A sequence-level model predicts every
// output each cycle, and literal expectations at key points pin the model.
module tb_sawtooth_sweep_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [2:0]  lo_sel;
    logic [2:0]  hi_sel;
    logic [15:0] dwell;
    logic [7:0]  loops;
    logic [2:0]  freq_select;
    logic        step_strobe;
    logic        wave_rst;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    bit check_en = 0;

    // Model outputs
    int exp_freq;
    int exp_strobe;
    int exp_wave;
    int exp_busy;
    int exp_done;
    int exp_err;

    // Model sweep context: one loop of levels, position and dwell progress
    int seq[$];
    int m_idx;
    int m_elapsed;
    int m_dwell;
    int m_loops;
    int m_loops_done;
    bit m_running = 0;
    bit m_done_phase = 0;

    sawtooth_sweep_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .lo_sel      (lo_sel),
        .hi_sel      (hi_sel),
        .dwell       (dwell),
        .loops       (loops),
        .freq_select (freq_select),
        .step_strobe (step_strobe),
        .wave_rst    (wave_rst),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // 25 MHz clock
    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #5;
        end
    endtask

    // Drive a configuration with a one-cycle start pulse; returns just after the start edge
    task automatic applyStimulus(input logic [1:0] m, input logic [2:0] lo, input logic [2:0] hi,
                                 input logic [15:0] dw, input logic [7:0] lp);
        mode       = m;
        lo_sel     = lo;
        hi_sel     = hi;
        dwell      = dw;
        loops      = lp;
        start      = 1'b1;
        strobe_cnt = 0;
        cycles(1);
        start = 1'b0;
    endtask

    // Sequence-level model: a sweep is a list of levels walked with a fixed dwell per entry
    always @(posedge clk) begin
        exp_strobe = 0;
        exp_wave   = 0;
        exp_done   = 0;
        exp_err    = 0;
        if (!reset_n) begin
            exp_freq     = 0;
            exp_busy     = 0;
            m_running    = 0;
            m_done_phase = 0;
        end else if (m_done_phase) begin
            m_done_phase = 0;
        end else if (m_running) begin
            if (stop) begin
                m_running = 0;
                exp_busy  = 0;
            end else begin
                m_elapsed++;
                if (m_elapsed == m_dwell) begin
                    m_elapsed = 0;
                    m_idx++;
                    if (m_idx == seq.size()) begin
                        m_idx = 0;
                        m_loops_done++;
                        if (m_loops != 0 && m_loops_done == m_loops) begin
                            m_running    = 0;
                            m_done_phase = 1;
                            exp_busy     = 0;
                            exp_done     = 1;
                        end else begin
                            exp_freq   = seq[0];
                            exp_strobe = 1;
                        end
                    end else begin
                        exp_freq   = seq[m_idx];
                        exp_strobe = 1;
                    end
                end
            end
        end else if (start && !stop) begin
            if (lo_sel > hi_sel) begin
                exp_err = 1;
            end else begin
                seq.delete();
                case (mode)
                    2'b00: for (int v = int'(lo_sel); v <= int'(hi_sel); v++) seq.push_back(v);
                    2'b01: for (int v = int'(hi_sel); v >= int'(lo_sel); v--) seq.push_back(v);
                    2'b10: begin
                        for (int v = int'(lo_sel); v <= int'(hi_sel); v++) seq.push_back(v);
                        for (int v = int'(hi_sel) - 1; v > int'(lo_sel); v--) seq.push_back(v);
                    end
                    default: seq.push_back(int'(lo_sel));
                endcase
                m_dwell      = (dwell == 0) ? 1 : int'(dwell);
                m_loops      = int'(loops);
                m_idx        = 0;
                m_elapsed    = 0;
                m_loops_done = 0;
                m_running    = 1;
                exp_freq     = seq[0];
                exp_strobe   = 1;
                exp_wave     = 1;
                exp_busy     = 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_freq", 16'(freq_select), 16'(exp_freq));
            checkOutput("model_strobe", 16'(step_strobe), 16'(exp_strobe));
            checkOutput("model_wave_rst", 16'(wave_rst), 16'(exp_wave));
            checkOutput("model_busy", 16'(busy), 16'(exp_busy));
            checkOutput("model_done", 16'(done), 16'(exp_done));
            checkOutput("model_err", 16'(err), 16'(exp_err));
            if (step_strobe === 1'b1) strobe_cnt++;
        end
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        mode    = 2'b00;
        lo_sel  = 3'd0;
        hi_sel  = 3'd0;
        dwell   = 16'd0;
        loops   = 8'd0;
        #5;
        cycles(2);
        check_en = 1;
        checkOutput("reset_freq", 16'(freq_select), 16'd0);
        checkOutput("reset_busy", 16'(busy), 16'd0);
        checkOutput("reset_strobe", 16'(step_strobe), 16'd0);
        reset_n = 1'b1;
        cycles(2);

        // Up sweep 0..3, dwell 4, one loop
        applyStimulus(2'b00, 3'd0, 3'd3, 16'd4, 8'd1);
        checkOutput("t1_start_freq", 16'(freq_select), 16'd0);
        checkOutput("t1_start_wave_rst", 16'(wave_rst), 16'd1);
        checkOutput("t1_start_strobe", 16'(step_strobe), 16'd1);
        checkOutput("t1_start_busy", 16'(busy), 16'd1);
        cycles(15);
        checkOutput("t1_pre_done_freq", 16'(freq_select), 16'd3);
        checkOutput("t1_pre_done", 16'(done), 16'd0);
        cycles(1);
        checkOutput("t1_done", 16'(done), 16'd1);
        checkOutput("t1_done_busy", 16'(busy), 16'd0);
        checkOutput("t1_done_freq", 16'(freq_select), 16'd3);
        checkOutput("t1_strobes", 16'(strobe_cnt), 16'd4);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        checkOutput("t1_start_in_done_busy", 16'(busy), 16'd0);
        checkOutput("t1_start_in_done_wave", 16'(wave_rst), 16'd0);
        cycles(2);

        // Ping-pong 2..4, dwell 2, two loops
        applyStimulus(2'b10, 3'd2, 3'd4, 16'd2, 8'd2);
        checkOutput("t2_start_freq", 16'(freq_select), 16'd2);
        cycles(3);
        checkOutput("t2_freq_e3", 16'(freq_select), 16'd3);
        cycles(3);
        checkOutput("t2_freq_e6", 16'(freq_select), 16'd3);
        cycles(2);
        checkOutput("t2_reload_freq", 16'(freq_select), 16'd2);
        checkOutput("t2_reload_strobe", 16'(step_strobe), 16'd1);
        cycles(8);
        checkOutput("t2_done", 16'(done), 16'd1);
        checkOutput("t2_done_freq", 16'(freq_select), 16'd3);
        cycles(2);

        // Down 5..1, dwell 0, infinite; config churn and restart mid-sweep; stop after 12
        applyStimulus(2'b01, 3'd1, 3'd5, 16'd0, 8'd0);
        checkOutput("t3_start_freq", 16'(freq_select), 16'd5);
        cycles(1);
        checkOutput("t3_freq_e1", 16'(freq_select), 16'd4);
        mode   = 2'b00;
        lo_sel = 3'd0;
        hi_sel = 3'd7;
        start  = 1'b1;
        cycles(1);
        start = 1'b0;
        checkOutput("t3_busy_restart_freq", 16'(freq_select), 16'd3);
        checkOutput("t3_busy_restart_wave", 16'(wave_rst), 16'd0);
        cycles(9);
        checkOutput("t3_freq_e11", 16'(freq_select), 16'd4);
        stop = 1'b1;
        cycles(1);
        stop = 1'b0;
        checkOutput("t3_stop_busy", 16'(busy), 16'd0);
        checkOutput("t3_stop_freq", 16'(freq_select), 16'd4);
        checkOutput("t3_stop_done", 16'(done), 16'd0);
        cycles(2);

        // Rejected start, then start with stop in IDLE
        mode   = 2'b00;
        lo_sel = 3'd6;
        hi_sel = 3'd2;
        start  = 1'b1;
        cycles(1);
        start = 1'b0;
        checkOutput("t4_err", 16'(err), 16'd1);
        checkOutput("t4_err_busy", 16'(busy), 16'd0);
        checkOutput("t4_err_freq", 16'(freq_select), 16'd4);
        cycles(1);
        checkOutput("t4_err_pulse_end", 16'(err), 16'd0);
        lo_sel = 3'd1;
        hi_sel = 3'd3;
        start  = 1'b1;
        stop   = 1'b1;
        cycles(1);
        start = 1'b0;
        stop  = 1'b0;
        checkOutput("t4_startstop_busy", 16'(busy), 16'd0);
        checkOutput("t4_startstop_err", 16'(err), 16'd0);
        checkOutput("t4_startstop_wave", 16'(wave_rst), 16'd0);
        cycles(1);

        // Hold at 7, dwell 3, three loops
        applyStimulus(2'b11, 3'd7, 3'd7, 16'd3, 8'd3);
        checkOutput("t5_start_freq", 16'(freq_select), 16'd7);
        cycles(8);
        checkOutput("t5_pre_done", 16'(done), 16'd0);
        checkOutput("t5_pre_done_busy", 16'(busy), 16'd1);
        cycles(1);
        checkOutput("t5_done", 16'(done), 16'd1);
        checkOutput("t5_strobes", 16'(strobe_cnt), 16'd3);
        checkOutput("t5_done_freq", 16'(freq_select), 16'd7);
        cycles(2);

        // Reset mid-sweep, with start held during reset
        applyStimulus(2'b00, 3'd2, 3'd6, 16'd5, 8'd0);
        cycles(6);
        checkOutput("t6_freq_e6", 16'(freq_select), 16'd3);
        reset_n = 1'b0;
        start   = 1'b1;
        cycles(1);
        checkOutput("t6_reset_freq", 16'(freq_select), 16'd0);
        checkOutput("t6_reset_busy", 16'(busy), 16'd0);
        checkOutput("t6_reset_strobe", 16'(step_strobe), 16'd0);
        cycles(1);
        checkOutput("t6_reset_start_busy", 16'(busy), 16'd0);
        checkOutput("t6_reset_start_wave", 16'(wave_rst), 16'd0);
        reset_n = 1'b1;
        start   = 1'b0;
        cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
